// File: rtl/uart_tx_rx_if.sv
// Parallel-side bus of the looped-back UART: transmit request, received word, status pulses.
// The testbench drives the master side and the uart_tx_rx core sits on the slave side.
interface uart_tx_rx_if #(
  parameter int size = 32
);
  logic            NewData;
  logic [size-1:0] DataIn;
  logic            force_parity_error;
  logic            TransmittedSerialData;
  logic            DoneTx;
  logic [size-1:0] DataOut;
  logic            DoneRx;
  logic            Flag_Rx;

  modport master (
    output NewData, DataIn, force_parity_error,
    input  TransmittedSerialData, DoneTx, DataOut, DoneRx, Flag_Rx
  );

  modport slave (
    input  NewData, DataIn, force_parity_error,
    output TransmittedSerialData, DoneTx, DataOut, DoneRx, Flag_Rx
  );
endinterface

// File: rtl/uart_tx_rx.sv
// Looped-back UART with one bit per baud clock: frame = start, size data bits LSB first, even parity, stop.
// Rx reports a word 35 clocks after Tx starts; Tx retransmits on a receive error, with no backpressure.
module uart_tx_rx #(
  parameter int size = 32
) (
  input  logic        CLK_Baudin,
  input  logic        RstTx,
  input  logic        RstRx,
  uart_tx_rx_if.slave bus
);
  localparam int CW = (size > 1) ? $clog2(size) : 1;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_CHECK} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [size-1:0] tx_data_q, tx_data_d;
  logic            tx_force_q, tx_force_d;
  logic            line_q, line_d;
  logic            done_tx_q, done_tx_d;

  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [size-1:0] rx_shift_q, rx_shift_d;
  logic            rx_par_q, rx_par_d;
  logic [size-1:0] data_out_q, data_out_d;
  logic            done_rx_q, done_rx_d;
  logic            flag_q, flag_d;

  // Tx state names what the line shows for the current clock.
  always_ff @(posedge CLK_Baudin) begin
    if (RstTx) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_data_q  <= '0;
      tx_force_q <= 1'b0;
      line_q     <= 1'b1;
      done_tx_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_force_q <= tx_force_d;
      line_q     <= line_d;
      done_tx_q  <= done_tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_data_d  = tx_data_q;
    tx_force_d = tx_force_q;
    line_d     = line_q;
    done_tx_d  = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        line_d = 1'b1;
        if (bus.NewData) begin
          tx_data_d  = bus.DataIn;
          tx_force_d = bus.force_parity_error;
          line_d     = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        line_d     = tx_data_q[0];
        tx_cnt_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        if (tx_cnt_q == CW'(size - 1)) begin
          line_d     = (^tx_data_q) ^ tx_force_q;
          tx_state_d = TX_PARITY;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
          line_d   = tx_data_q[tx_cnt_d];
        end
      end
      TX_PARITY: begin
        line_d     = 1'b1;
        tx_state_d = TX_STOP;
      end
      TX_STOP: begin
        line_d     = 1'b1;
        tx_state_d = TX_CHECK;
      end
      TX_CHECK: begin
        // A flagged frame is resent immediately; only the first attempt carries the forced error.
        if (flag_q) begin
          line_d     = 1'b0;
          tx_force_d = 1'b0;
          tx_state_d = TX_START;
        end else begin
          line_d     = 1'b1;
          done_tx_d  = 1'b1;
          tx_state_d = TX_IDLE;
        end
      end
      default: begin
        line_d     = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_Baudin) begin
    if (RstRx) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      data_out_q <= '0;
      done_rx_q  <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      data_out_q <= data_out_d;
      done_rx_q  <= done_rx_d;
      flag_q     <= flag_d;
    end
  end

  // Rx samples the registered Tx line, one clock behind what Tx drives.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    data_out_d = data_out_q;
    done_rx_d  = 1'b0;
    flag_d     = flag_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (!line_q) begin
          rx_cnt_d   = '0;
          flag_d     = 1'b0;
          rx_state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        rx_shift_d = {line_q, rx_shift_q[size-1:1]};
        if (rx_cnt_q == CW'(size - 1)) begin
          rx_state_d = RX_PARITY;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_PARITY: begin
        rx_par_d   = line_q;
        rx_state_d = RX_STOP;
      end
      RX_STOP: begin
        if ((rx_par_q == ^rx_shift_q) && line_q) begin
          data_out_d = rx_shift_q;
          done_rx_d  = 1'b1;
          flag_d     = 1'b0;
        end else begin
          flag_d = 1'b1;
        end
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign bus.TransmittedSerialData = line_q;
  assign bus.DoneTx                = done_tx_q;
  assign bus.DataOut               = data_out_q;
  assign bus.DoneRx                = done_rx_q;
  assign bus.Flag_Rx               = flag_q;
endmodule

// File: tb/tb_uart_tx_rx.sv
// Directed bench for uart_tx_rx: a vector table of frames plus hand-written reset sequences.
module tb_uart_tx_rx;
  logic clk = 1'b0;
  logic rst_tx;
  logic rst_rx;
  int   n_pass = 0;
  int   n_total = 0;
  logic [31:0] last_good = 32'h0;

  uart_tx_rx_if #(.size(32)) bus ();

  uart_tx_rx #(.size(32)) dut (
    .CLK_Baudin(clk),
    .RstTx     (rst_tx),
    .RstRx     (rst_rx),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        force_err;
    logic        mid_nd;
    logic        exp_par;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Entered #1 after edge E0 of a frame; returns #1 after E0+36.
  task automatic frame(input logic [31:0] d, input logic fp, input logic good, input logic mid_nd);
    logic [31:0] got;
    got = '0;
    chk("start_bit", {31'b0, bus.TransmittedSerialData}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      step();
      got[i] = bus.TransmittedSerialData;
      if (i == 0) chk("flag_clr_at_start", {31'b0, bus.Flag_Rx}, 32'h0);
      if (mid_nd && i == 5) begin
        bus.NewData = 1'b1;
        bus.DataIn = ~d;
        bus.force_parity_error = 1'b1;
      end
      if (mid_nd && i == 8) begin
        bus.NewData = 1'b0;
        bus.DataIn = '0;
        bus.force_parity_error = 1'b0;
      end
    end
    chk("data_bits", got, d);
    step();
    chk("parity_bit", {31'b0, bus.TransmittedSerialData}, {31'b0, fp});
    step();
    chk("stop_bit", {31'b0, bus.TransmittedSerialData}, 32'h1);
    step();
    if (good) begin
      chk("donerx_pulse", {31'b0, bus.DoneRx}, 32'h1);
      chk("dataout", bus.DataOut, d);
      chk("flag_ok", {31'b0, bus.Flag_Rx}, 32'h0);
      last_good = d;
    end else begin
      chk("donerx_none", {31'b0, bus.DoneRx}, 32'h0);
      chk("dataout_kept", bus.DataOut, last_good);
      chk("flag_err", {31'b0, bus.Flag_Rx}, 32'h1);
    end
    step();
    if (good) begin
      chk("donetx_pulse", {31'b0, bus.DoneTx}, 32'h1);
      chk("line_idle", {31'b0, bus.TransmittedSerialData}, 32'h1);
    end else begin
      chk("donetx_none", {31'b0, bus.DoneTx}, 32'h0);
      chk("retx_start", {31'b0, bus.TransmittedSerialData}, 32'h0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    bus.NewData = 1'b1;
    bus.DataIn = v.data;
    bus.force_parity_error = v.force_err;
    step();
    bus.NewData = 1'b0;
    bus.DataIn = '0;
    bus.force_parity_error = 1'b0;
    frame(v.data, v.exp_par ^ v.force_err, !v.force_err, v.mid_nd);
    if (v.force_err) frame(v.data, v.exp_par, 1'b1, 1'b0);
    step();
    chk("donetx_width", {31'b0, bus.DoneTx}, 32'h0);
    chk("donerx_width", {31'b0, bus.DoneRx}, 32'h0);
  endtask

  initial begin
    int n_rx;
    int n_low;
    vecs[0] = '{data: 32'hA5A5F0F0, force_err: 1'b1, mid_nd: 1'b0, exp_par: 1'b0};
    vecs[1] = '{data: 32'hA5A5F0F0, force_err: 1'b0, mid_nd: 1'b0, exp_par: 1'b0};
    vecs[2] = '{data: 32'h00000001, force_err: 1'b0, mid_nd: 1'b1, exp_par: 1'b1};
    vecs[3] = '{data: 32'h12345678, force_err: 1'b1, mid_nd: 1'b1, exp_par: 1'b1};
    vecs[4] = '{data: 32'hFFFFFFFF, force_err: 1'b0, mid_nd: 1'b0, exp_par: 1'b0};

    bus.NewData = 1'b0;
    bus.DataIn = '0;
    bus.force_parity_error = 1'b0;
    rst_tx = 1'b1;
    rst_rx = 1'b1;
    step();
    step();
    chk("rst_line", {31'b0, bus.TransmittedSerialData}, 32'h1);
    chk("rst_donetx", {31'b0, bus.DoneTx}, 32'h0);
    chk("rst_donerx", {31'b0, bus.DoneRx}, 32'h0);
    chk("rst_flag", {31'b0, bus.Flag_Rx}, 32'h0);
    chk("rst_dataout", bus.DataOut, 32'h0);
    rst_tx = 1'b0;
    rst_rx = 1'b0;
    step();
    chk("idle_line", {31'b0, bus.TransmittedSerialData}, 32'h1);

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // Both sides reset at E0+10 of a frame in flight.
    @(negedge clk);
    bus.NewData = 1'b1;
    bus.DataIn = 32'hCAFEF00D;
    step();
    bus.NewData = 1'b0;
    bus.DataIn = '0;
    for (int i = 1; i <= 9; i++) step();
    rst_tx = 1'b1;
    rst_rx = 1'b1;
    step();
    chk("midrst_line", {31'b0, bus.TransmittedSerialData}, 32'h1);
    chk("midrst_flag", {31'b0, bus.Flag_Rx}, 32'h0);
    chk("midrst_donerx", {31'b0, bus.DoneRx}, 32'h0);
    chk("midrst_dataout", bus.DataOut, 32'h0);
    rst_tx = 1'b0;
    rst_rx = 1'b0;
    last_good = 32'h0;
    n_rx = 0;
    n_low = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.DoneRx) n_rx++;
      if (!bus.TransmittedSerialData) n_low++;
    end
    chk("midrst_no_donerx", n_rx, 0);
    chk("midrst_line_quiet", n_low, 0);
    chk("midrst_flag_after", {31'b0, bus.Flag_Rx}, 32'h0);
    run_vec(vecs[2]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
